// File: rtl/result_demux8_32.sv
// result_demux8_32: registered 1-to-8 result demux with per-channel valid/ready and illegal-code drop counting
module result_demux8_32 #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          sel,
  input  logic [DATA_W-1:0]   in_data,
  output logic [7:0]          out_valid,
  input  logic [7:0]          out_ready,
  output logic [8*DATA_W-1:0] out_data,
  output logic                err_sel,
  output logic [CNT_W-1:0]    drop_count
);
  logic       legal;
  logic [2:0] ch;
  logic       xfer;
  logic [7:0] wr;
  always_comb begin
    legal = sel inside {4'b0000, 4'b0001, 4'b0010, 4'b1100, 4'b0110, 4'b0111};
    ch = (sel == 4'b1100) ? 3'd3 : sel[2:0];
    in_ready = ~legal | ~out_valid[ch] | out_ready[ch];
    xfer = in_valid & in_ready;
    wr = (xfer & legal) ? (8'd1 << ch) : 8'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data <= '0;
      err_sel <= 1'b0;
      drop_count <= '0;
    end else begin
      out_valid <= (out_valid & ~out_ready) | wr;
      for (int k = 0; k < 8; k++)
        if (wr[k]) out_data[k*DATA_W +: DATA_W] <= in_data;
      if (xfer & ~legal) begin
        err_sel <= 1'b1;
        drop_count <= drop_count + CNT_W'(drop_count != '1);
      end
    end
  end
endmodule

// File: tb/tb_result_demux8_32.sv
// tb_result_demux8_32: scoreboard bench for the registered result demux
module tb_result_demux8_32;
  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   sel;
  logic [31:0]  in_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [255:0] out_data;
  logic         err_sel;
  logic [7:0]   drop_count;
  int           exp_ch;
  int           checks;
  int           errors;
  logic [255:0] exp_data;
  typedef struct {
    int          ch;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];
  result_demux8_32 dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sel(sel),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .err_sel(err_sel),
    .drop_count(drop_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [3:0] s, input int c, input logic [31:0] d);
    in_valid = 1'b1;
    sel = s;
    exp_ch = c;
    in_data = d;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          bit found;
          found = 1'b0;
          for (int i = 0; i < q.size(); i++) begin
            if (!found && q[i].ch == k) begin
              chk($sformatf("deliver ch%0d", k), {224'd0, out_data[k*32 +: 32]}, {224'd0, q[i].d});
              q.delete(i);
              found = 1'b1;
            end
          end
          if (!found) chk($sformatf("unexpected word ch%0d", k), 256'd1, 256'd0);
        end
      end
      chk("reserved ch4/ch5", {190'd0, out_valid[5:4], out_data[191:128]}, 256'd0);
      if (in_valid && in_ready && exp_ch >= 0) q.push_back('{exp_ch, in_data});
    end
  end
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    sel = 4'd0;
    exp_ch = -1;
    in_data = 32'd0;
    out_ready = 8'd0;
    tick();
    tick();
    chk("reset out_valid", {248'd0, out_valid}, 256'd0);
    chk("reset out_data", out_data, 256'd0);
    chk("reset err/drop", {247'd0, err_sel, drop_count}, 256'd0);
    rst = 1'b0;
    put(4'b0001, 1, 32'hDEADBEEF);
    #1;
    chk("ready ch1 empty", {255'd0, in_ready}, 256'd1);
    tick();
    in_valid = 1'b0;
    exp_data = '0;
    exp_data[32 +: 32] = 32'hDEADBEEF;
    chk("ch1 load valid", {248'd0, out_valid}, 256'h02);
    chk("ch1 load data", out_data, exp_data);
    put(4'b1100, 3, 32'h0000_00AA);
    #1;
    chk("ready ch3 while ch1 full", {255'd0, in_ready}, 256'd1);
    tick();
    in_valid = 1'b0;
    exp_data[96 +: 32] = 32'h0000_00AA;
    chk("ch3 load valid", {248'd0, out_valid}, 256'h0A);
    chk("ch3 load data", out_data, exp_data);
    put(4'b0001, 1, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall ready", {255'd0, in_ready}, 256'd0);
      chk("stall slice1", {224'd0, out_data[63:32]}, {224'd0, 32'hDEADBEEF});
      tick();
    end
    out_ready = 8'h02;
    #1;
    chk("ready on drain", {255'd0, in_ready}, 256'd1);
    tick();
    in_valid = 1'b0;
    out_ready = 8'h00;
    chk("drain+write valid", {248'd0, out_valid}, 256'h0A);
    chk("drain+write slice1", {224'd0, out_data[63:32]}, {224'd0, 32'hCAFEF00D});
    out_ready = 8'h0A;
    tick();
    out_ready = 8'h00;
    exp_data[32 +: 32] = 32'hCAFEF00D;
    chk("drained valid", {248'd0, out_valid}, 256'h00);
    chk("drained data kept", out_data, exp_data);
    put(4'b0100, -1, 32'h5555_5555);
    #1;
    chk("ready illegal", {255'd0, in_ready}, 256'd1);
    tick();
    in_valid = 1'b0;
    chk("illegal no valid", {248'd0, out_valid}, 256'h00);
    chk("illegal data kept", out_data, exp_data);
    chk("err/drop after 1", {247'd0, err_sel, drop_count}, {247'd0, 1'b1, 8'd1});
    for (int i = 1; i < 300; i++) begin
      logic [3:0] bad[6];
      bad = '{4'b0100, 4'b0101, 4'b0011, 4'b1000, 4'b1111, 4'b1101};
      put(bad[i % 6], -1, 32'(i));
      #1;
      if (i % 50 == 0) chk("ready illegal loop", {255'd0, in_ready}, 256'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("drop saturate", {247'd0, err_sel, drop_count}, {247'd0, 1'b1, 8'd255});
    chk("illegal loop no valid", {248'd0, out_valid}, 256'h00);
    put(4'b0000, 0, 32'h1111_1111);
    tick();
    put(4'b0010, 2, 32'h2222_2222);
    tick();
    put(4'b0110, 6, 32'h6666_6666);
    tick();
    put(4'b0111, 7, 32'h1234_5678);
    tick();
    in_valid = 1'b0;
    exp_data[0 +: 32] = 32'h1111_1111;
    exp_data[64 +: 32] = 32'h2222_2222;
    exp_data[192 +: 32] = 32'h6666_6666;
    exp_data[224 +: 32] = 32'h1234_5678;
    chk("multi load valid", {248'd0, out_valid}, 256'hC5);
    chk("multi load data", out_data, exp_data);
    out_ready = 8'h80;
    tick();
    out_ready = 8'h00;
    chk("ch7 drain valid", {248'd0, out_valid}, 256'h45);
    chk("ch7 slice kept", {224'd0, out_data[255:224]}, {224'd0, 32'h1234_5678});
    out_ready = 8'h04;
    tick();
    out_ready = 8'h00;
    chk("ch2 drain valid", {248'd0, out_valid}, 256'h41);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst valid", {248'd0, out_valid}, 256'd0);
    chk("async rst data", out_data, 256'd0);
    chk("async rst err/drop", {247'd0, err_sel, drop_count}, 256'd0);
    q.delete();
    tick();
    rst = 1'b0;
    put(4'b0110, 6, 32'h0BAD_F00D);
    tick();
    in_valid = 1'b0;
    chk("post-reset load", {248'd0, out_valid}, 256'h40);
    out_ready = 8'h40;
    tick();
    out_ready = 8'h00;
    chk("post-reset drained", {248'd0, out_valid}, 256'h00);
    chk("scoreboard empty", {224'd0, 32'(q.size())}, 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
